fp_result_wb_buffer: RTL and testbench
======================================

# fp_result_wb_buffer

Result buffer directly downstream of the 3-stage FP add/sub unit. It captures each completed result (value, rd, write-enables) into a small FIFO and presents it to the FP/integer writeback port with a valid/ready handshake. When writeback stalls, it back-pressures the add/sub pipeline through that unit's `en` input. It also answers RAW-hazard queries for destinations still held in the buffer.

## Interface
- `DEPTH`, 4 — FIFO entries; power of two, ≥2.
- `DATA_W`, 32 — result width.
- `clk` in 1 — clock.
- `rst` in 1 — reset; asynchronous, active-low.
- `flush` in 1 — synchronous buffer clear.
- `in_valid` in 1 — result valid; driven by add/sub `p_result`.
- `in_data` in DATA_W — add/sub `sum`.
- `in_rd` in 5 — destination register.
- `in_reg_write` in 1 — integer-file write enable.
- `in_fp_reg_write` in 1 — FP-file write enable.
- `unit_en` out 1 — drives add/sub `en`; doubles as input ready.
- `wb_valid` out 1 — head entry valid.
- `wb_ready` in 1 — writeback accepts the head entry.
- `wb_data` out DATA_W, `wb_rd` out 5, `wb_reg_write` out 1, `wb_fp_reg_write` out 1 — head entry fields.
- `count` out $clog2(DEPTH)+1 — occupancy.
- `chk_rs1`, `chk_rs2`, `chk_rs3` in 5 each — hazard query registers.
- `chk_is_fp` in 3 — bit i set: query i targets the FP file.
- `chk_hit` out 3 — bit i: query i matches a buffered destination.

## Operation
- Storage: DEPTH entries {data, rd, reg_write, fp_reg_write}. Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is held as a separate register.
- `pop = wb_valid & wb_ready`; `push = in_valid & unit_en & ~flush`.
- `unit_en = (count != DEPTH) | pop`. There is a combinational path from `wb_ready` to `unit_en` by design.
- The add/sub output holds while `en` = 0, so a result is consumed only at a clock edge where `unit_en` = 1. No result is duplicated and none is lost.
- Push writes at `wr_ptr`; pop advances `rd_ptr`.
- `count` update: push only → +1; pop only → −1; both or neither → unchanged.
- Push and pop in the same cycle are legal at every occupancy, including full (`unit_en` = 1 via pop) and count = 1.
- `wb_*` fields are the head entry. `wb_valid = (count != 0)`, except in the bypass case (see Configuration).
- `flush`: at the next edge, count → 0 and both pointers → 0.
  - An input present in the flush cycle is dropped.
  - `wb_valid` falls the cycle after flush.
  - A pop in the flush cycle is still accepted by writeback.
- Hazard check, per query i:
  - FP query (`chk_is_fp[i]` = 1): hit if any valid entry has `fp_reg_write` = 1 and `rd == chk_rs_i`.
  - Integer query (`chk_is_fp[i]` = 0): hit if any valid entry has `reg_write` = 1, `rd == chk_rs_i`, and `rd != 0`.
  - The check is combinational on current contents only. The incoming `in_*` is excluded because the add/sub unit's own in-flight tracking covers it.
- Reset, asynchronous: pointers, count and all entries → 0. Outputs after reset: `wb_valid` = 0, `wb_data` = 0, `wb_rd` = 0, `wb_reg_write` = 0, `wb_fp_reg_write` = 0, `count` = 0, `chk_hit` = 0, `unit_en` = 1.
- Reset mid-operation discards all contents. Nothing drains.

## Timing
- Latency without bypass: pushed at edge N → `wb_valid` high in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- Full with `wb_ready` = 0: `unit_en` = 0 in the same cycle, so the add/sub pipeline freezes. It resumes in the first cycle `wb_ready` = 1.
- Once asserted, `wb_valid` stays high and `wb_*` stay stable until pop or flush.
- `chk_hit` reflects contents as updated at the latest edge.

## Configuration
- `FP_WB_BYPASS_EN` defined: when count = 0 and `in_valid` = 1 and `flush` = 0:
  - `wb_valid` = 1 and `wb_*` = `in_*` combinationally.
  - If `wb_ready` = 1, the result passes through with zero latency and is not stored; count stays 0.
  - If `wb_ready` = 0, the result is pushed normally.
- `FP_WB_BYPASS_EN` undefined: every result is stored first; minimum latency is one cycle.

## Test plan
- Reset release, `in_valid` = 0 → `wb_valid` = 0, `count` = 0, `unit_en` = 1, `chk_hit` = 0.
- Push `in_data` = 0x3F800000, rd = 5, fp write = 1, with `wb_ready` = 1 → `wb_data` = 0x3F800000, `wb_rd` = 5 one cycle later without bypass, same cycle with bypass. Before the pop, `chk_rs1` = 5 with FP query → `chk_hit[0]` = 1.
- `wb_ready` = 0, five back-to-back pushes 0x1..0x5 with DEPTH = 4 → `count` = 4 and `unit_en` = 0 after the 4th push; 0x5 stays held upstream. Raising `wb_ready` → pops in order 0x1, 0x2, …, 0x5 with nothing dropped or duplicated.
- Full buffer, `wb_ready` = 1 and `in_valid` = 1 held for 8 cycles → `count` stays 4, `unit_en` = 1, output order is FIFO, pointers wrap.
- Integer query: entry with rd = 0 and `reg_write` = 1, `chk_rs2` = 0 with integer query → `chk_hit[1]` = 0. Entry with rd = 7 and `fp_reg_write` = 0, FP query for 7 → no hit.
- 3 entries plus `flush` with a simultaneous `in_valid` → `count` = 0 and `wb_valid` = 0 next cycle, and the incoming result is not stored. Assert `rst` low mid-burst → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/fp_result_wb_buffer.sv
// Writeback FIFO behind the FP add/sub unit: holds results, stalls the unit via unit_en, answers RAW queries.
// Optional zero-latency pass-through when empty is enabled by defining FP_WB_BYPASS_EN.
module fp_result_wb_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [4:0]                 in_rd,
  input  logic                       in_reg_write,
  input  logic                       in_fp_reg_write,
  output logic                       unit_en,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [DATA_W-1:0]          wb_data,
  output logic [4:0]                 wb_rd,
  output logic                       wb_reg_write,
  output logic                       wb_fp_reg_write,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [4:0]                 chk_rs1,
  input  logic [4:0]                 chk_rs2,
  input  logic [4:0]                 chk_rs3,
  input  logic [2:0]                 chk_is_fp,
  output logic [2:0]                 chk_hit
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [4:0]        rd_q   [DEPTH];
  logic              rw_q   [DEPTH];
  logic              fw_q   [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;

  logic bypass, push, pop, push_store, pop_store;
  logic [4:0] rs [3];

  assign rs[0] = chk_rs1;
  assign rs[1] = chk_rs2;
  assign rs[2] = chk_rs3;

`ifdef FP_WB_BYPASS_EN
  assign bypass = (count == '0) & in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    wb_valid        = (count != '0);
    wb_data         = data_q[rd_ptr];
    wb_rd           = rd_q[rd_ptr];
    wb_reg_write    = rw_q[rd_ptr];
    wb_fp_reg_write = fw_q[rd_ptr];
    if (bypass) begin
      wb_valid        = 1'b1;
      wb_data         = in_data;
      wb_rd           = in_rd;
      wb_reg_write    = in_reg_write;
      wb_fp_reg_write = in_fp_reg_write;
    end
  end

  assign pop        = wb_valid & wb_ready;
  assign unit_en    = (count != CW'(DEPTH)) | pop;
  assign push       = in_valid & unit_en & ~flush;
  // A bypassed result handed straight to writeback never occupies an entry.
  assign push_store = push & ~(bypass & wb_ready);
  assign pop_store  = pop & (count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
        rw_q[i]   <= 1'b0;
        fw_q[i]   <= 1'b0;
      end
    end else begin
      if (push_store) begin
        data_q[wr_ptr] <= in_data;
        rd_q[wr_ptr]   <= in_rd;
        rw_q[wr_ptr]   <= in_reg_write;
        fw_q[wr_ptr]   <= in_fp_reg_write;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_store) wr_ptr <= wr_ptr + PW'(1);
        if (pop_store)  rd_ptr <= rd_ptr + PW'(1);
        case ({push_store, pop_store})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry e is live when its distance from the head is below the occupancy.
  logic [PW-1:0] off;
  always_comb begin
    chk_hit = '0;
    off     = '0;
    for (int q = 0; q < 3; q++) begin
      for (int e = 0; e < DEPTH; e++) begin
        off = PW'(e) - rd_ptr;
        if (({1'b0, off} < count) && (rd_q[e] == rs[q])) begin
          if (chk_is_fp[q]) begin
            if (fw_q[e]) chk_hit[q] = 1'b1;
          end else if (rw_q[e] && (rd_q[e] != 5'd0)) begin
            chk_hit[q] = 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_result_wb_buffer.sv
// Randomized + directed bench for fp_result_wb_buffer against a queue-based reference model.
module tb_fp_result_wb_buffer;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic clk, rst, flush, in_valid, in_reg_write, in_fp_reg_write, wb_ready;
  logic [DW-1:0] in_data, wb_data;
  logic [4:0] in_rd, wb_rd, chk_rs1, chk_rs2, chk_rs3;
  logic [2:0] chk_is_fp, chk_hit;
  logic unit_en, wb_valid, wb_reg_write, wb_fp_reg_write;
  logic [$clog2(DEPTH):0] count;

  fp_result_wb_buffer #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_fp_reg_write(in_fp_reg_write),
    .unit_en(unit_en), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_fp_reg_write(wb_fp_reg_write),
    .count(count), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rs3(chk_rs3),
    .chk_is_fp(chk_is_fp), .chk_hit(chk_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [4:0]    rd;
    logic          rw;
    logic          fw;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;
  logic last_cons;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a rising edge with inputs already set; checks mid-cycle, then advances the model.
  task automatic cycle();
    int   n;
    logic byp, ev, ep, eu;
    ent_t h;
    logic [2:0] eh;
    logic [4:0] rs;
    #4;
    n = mq.size();
    byp = 1'b0;
`ifdef FP_WB_BYPASS_EN
    byp = (n == 0) && in_valid && !flush;
`endif
    ev = (n != 0) || byp;
    ep = ev && wb_ready;
    eu = (n != DEPTH) || ep;
    chk("count", 64'(count), 64'(n));
    chk("wb_valid", 64'(wb_valid), 64'(ev));
    chk("unit_en", 64'(unit_en), 64'(eu));
    if (ev) begin
      h = byp ? ent_t'{in_data, in_rd, in_reg_write, in_fp_reg_write} : mq[0];
      chk("wb_fields", {wb_data, wb_rd, wb_reg_write, wb_fp_reg_write}, 64'(h));
    end
    eh = '0;
    for (int q = 0; q < 3; q++) begin
      rs = (q == 0) ? chk_rs1 : (q == 1) ? chk_rs2 : chk_rs3;
      foreach (mq[k]) begin
        if (chk_is_fp[q] && mq[k].fw && mq[k].rd == rs) eh[q] = 1'b1;
        if (!chk_is_fp[q] && mq[k].rw && mq[k].rd == rs && rs != 5'd0) eh[q] = 1'b1;
      end
    end
    chk("chk_hit", 64'(chk_hit), 64'(eh));
    @(posedge clk);
    last_cons = in_valid && eu;
    if (flush) mq.delete();
    else begin
      if (ep && n != 0) void'(mq.pop_front());
      if (in_valid && eu && !(byp && wb_ready))
        mq.push_back(ent_t'{in_data, in_rd, in_reg_write, in_fp_reg_write});
    end
    #1;
  endtask

  task automatic set_in(input logic v, input logic [DW-1:0] d, input logic [4:0] r,
                        input logic rw, input logic fw);
    in_valid = v; in_data = d; in_rd = r; in_reg_write = rw; in_fp_reg_write = fw;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_wbv"}, 64'(wb_valid), 64'd0);
    chk({tag, "_fields"}, {wb_data, wb_rd, wb_reg_write, wb_fp_reg_write}, 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_uen"}, 64'(unit_en), 64'd1);
    chk({tag, "_hit"}, 64'(chk_hit), 64'd0);
  endtask

  // Source behaves like the add/sub output: holds its result until unit_en takes it.
  task automatic rand_run(input int cycles, input int p_valid, input int p_ready, input int p_flush);
    for (int c = 0; c < cycles; c++) begin
      if (!in_valid || last_cons)
        set_in($urandom_range(99) < p_valid, $urandom, 5'($urandom_range(7)),
               1'($urandom), 1'($urandom));
      wb_ready  = $urandom_range(99) < p_ready;
      flush     = $urandom_range(99) < p_flush;
      chk_rs1   = 5'($urandom_range(7));
      chk_rs2   = 5'($urandom_range(7));
      chk_rs3   = 5'($urandom_range(7));
      chk_is_fp = 3'($urandom);
      cycle();
    end
    flush = 1'b0;
  endtask

  initial begin
    int d;
    rst = 1'b0; flush = 1'b0; wb_ready = 1'b0; last_cons = 1'b0;
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    chk_rs1 = '0; chk_rs2 = '0; chk_rs3 = '0; chk_is_fp = '0;
    repeat (2) @(posedge clk);
    #3;
    chk_reset_outs("rst_hold");
    @(posedge clk); #1;
    rst = 1'b1;
    cycle();
    chk_reset_outs("rst_rel");

    // Single FP result, RAW hit while buffered
    wb_ready = 1'b1;
    set_in(1'b1, 32'h3F80_0000, 5'd5, 1'b0, 1'b1);
    chk_rs1 = 5'd5; chk_is_fp = 3'b001;
    cycle();
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
`ifndef FP_WB_BYPASS_EN
    #4;
    chk("lat_data", 64'(wb_data), 64'h3F80_0000);
    chk("lat_rd", 64'(wb_rd), 64'd5);
    chk("raw_fp_hit", 64'(chk_hit[0]), 64'd1);
    #1 @(posedge clk); #1;
    void'(mq.pop_front());
`endif
    cycle();

    // Fill with writeback stalled: 0x5 must wait upstream
    wb_ready = 1'b0;
    d = 1;
    for (int c = 0; c < 5; c++) begin
      set_in(1'b1, DW'(d), 5'(d), 1'b1, 1'b0);
      cycle();
      if (last_cons) d++;
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_held", 64'(d), 64'd5);
    wb_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (last_cons) begin
        d++;
        if (d > 5) set_in(1'b0, '0, '0, 1'b0, 1'b0);
        else set_in(1'b1, DW'(d), 5'(d), 1'b1, 1'b0);
      end
      cycle();
    end

    // Refill, then sustained push+pop at full occupancy
    wb_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_in(1'b1, 32'h100 + DW'(c), 5'(c), 1'b0, 1'b1);
      cycle();
    end
    wb_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      set_in(1'b1, 32'h200 + DW'(c), 5'(c), 1'b1, 1'b1);
      cycle();
      chk("stream_count", 64'(count), 64'd4);
    end
    wb_ready = 1'b0; set_in(1'b0, '0, '0, 1'b0, 1'b0);
    flush = 1'b1; cycle(); flush = 1'b0;

    // x0 integer write never hazards; FP query misses an int-only entry
    set_in(1'b1, 32'hAA, 5'd0, 1'b1, 1'b0); cycle();
    set_in(1'b1, 32'hBB, 5'd7, 1'b1, 1'b0); cycle();
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    chk_rs1 = 5'd7; chk_rs2 = 5'd0; chk_rs3 = 5'd7; chk_is_fp = 3'b001;
    #4;
    chk("hit_pattern", 64'(chk_hit), 64'b100);
    #1 @(posedge clk); #1;
    cycle();

    // Flush with a simultaneous input
    set_in(1'b1, 32'hCC, 5'd3, 1'b0, 1'b1); cycle();
    chk("pre_flush_count", 64'(count), 64'd3);
    set_in(1'b1, 32'hDD, 5'd4, 1'b0, 1'b1);
    flush = 1'b1; wb_ready = 1'b1;
    cycle();
    flush = 1'b0; wb_ready = 1'b0; set_in(1'b0, '0, '0, 1'b0, 1'b0);
    #4;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_wbv", 64'(wb_valid), 64'd0);
    #1 @(posedge clk); #1;

    // Random traffic, then reset mid-burst
    rand_run(300, 70, 60, 3);
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    wb_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_in(1'b1, 32'h300 + DW'(c), 5'(c + 1), 1'b1, 1'b1);
      cycle();
    end
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    chk_rs1 = 5'd1; chk_is_fp = 3'b001;
    #2 rst = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    mq.delete();
    #4 rst = 1'b1;
    @(posedge clk); #1;
    last_cons = 1'b0;
    rand_run(500, 80, 50, 2);
    rand_run(300, 50, 90, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
